// File: rtl/button_pkg.sv
// Shared types and default timing constants for the pushbutton input path.
// Imported by button_event and any other block that handles debounced buttons.
package button_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        LONG    = 2'd2
    } btn_state_e;

    // Hold timings at a 100 MHz system clock.
    localparam int unsigned LONG_CYCLES_1S      = 100_000_000;
    localparam int unsigned REPEAT_CYCLES_250MS = 25_000_000;

endpackage

// File: rtl/button_event.sv
// Converts a debounced button level into one-cycle press/short/long/repeat/release
// events plus a registered held level. Edge register, timer and FSM in one module.
module button_event
    import button_pkg::*;
#(
    parameter int unsigned LONG_CYCLES   = LONG_CYCLES_1S,
    parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_250MS,
    parameter int unsigned CNT_W         = 27
) (
    input  logic clk,
    input  logic rst,
    input  logic pb_debounced,
    output logic press_pulse,
    output logic short_pulse,
    output logic long_pulse,
    output logic repeat_pulse,
    output logic release_pulse,
    output logic held
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             pb_prev_q;
    logic             press_d, short_d, long_d, repeat_d, release_d, held_d;
    logic             press_q, short_q, long_q, repeat_q, release_q, held_q;
    logic             rise;

    assign rise = pb_debounced & ~pb_prev_q;

    always_comb begin
        state_d   = state_q;
        timer_d   = timer_q;
        press_d   = 1'b0;
        short_d   = 1'b0;
        long_d    = 1'b0;
        repeat_d  = 1'b0;
        release_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                timer_d = '0;
                if (rise) begin
                    press_d = 1'b1;
                    state_d = PRESSED;
                end
            end
            PRESSED: begin
                // Release is tested first so it beats a same-cycle threshold.
                if (!pb_debounced) begin
                    short_d   = 1'b1;
                    release_d = 1'b1;
                    state_d   = IDLE;
                    timer_d   = '0;
                end else if (timer_q == LONG_LAST) begin
                    long_d  = 1'b1;
                    state_d = LONG;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            LONG: begin
                if (!pb_debounced) begin
                    release_d = 1'b1;
                    state_d   = IDLE;
                    timer_d   = '0;
                end else if (timer_q == REPEAT_LAST) begin
                    repeat_d = 1'b1;
                    timer_d  = '0;
                end else begin
                    timer_d = timer_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
        held_d = (state_d != IDLE);
    end

    // pb_prev resets high so a button held through reset must be released first.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            timer_q   <= '0;
            pb_prev_q <= 1'b1;
        end else begin
            state_q   <= state_d;
            timer_q   <= timer_d;
            pb_prev_q <= pb_debounced;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            press_q   <= 1'b0;
            short_q   <= 1'b0;
            long_q    <= 1'b0;
            repeat_q  <= 1'b0;
            release_q <= 1'b0;
            held_q    <= 1'b0;
        end else begin
            press_q   <= press_d;
            short_q   <= short_d;
            long_q    <= long_d;
            repeat_q  <= repeat_d;
            release_q <= release_d;
            held_q    <= held_d;
        end
    end

    assign press_pulse   = press_q;
    assign short_pulse   = short_q;
    assign long_pulse    = long_q;
    assign repeat_pulse  = repeat_q;
    assign release_pulse = release_q;
    assign held          = held_q;

endmodule

// File: tb/tb_button_event.sv
// Directed bench for button_event with LONG_CYCLES=8, REPEAT_CYCLES=4.
module tb_button_event;

    logic clk = 1'b0;
    logic rst;
    logic pb_debounced;
    logic press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held;

    int tests = 0;
    int fails = 0;

    // Per-scenario event log, sampled 1 time unit after each rising edge.
    int cyc;
    int n_press, n_short, n_long, n_rep, n_rel, n_held, n_stretch;
    int press_t, short_t, long_t, rel_t;
    int rep_t[$];
    logic p_press = 0, p_short = 0, p_long = 0, p_rep = 0, p_rel = 0;

    button_event #(.LONG_CYCLES(8), .REPEAT_CYCLES(4), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pb_debounced(pb_debounced),
        .press_pulse(press_pulse), .short_pulse(short_pulse), .long_pulse(long_pulse),
        .repeat_pulse(repeat_pulse), .release_pulse(release_pulse), .held(held)
    );

    always #5 clk = ~clk;

    task automatic clear();
        cyc = 0; n_press = 0; n_short = 0; n_long = 0; n_rep = 0; n_rel = 0;
        n_held = 0; n_stretch = 0; press_t = -1; short_t = -1; long_t = -1; rel_t = -1;
        rep_t.delete();
    endtask

    task automatic tick();
        @(posedge clk); #1;
        cyc++;
        if (press_pulse)   begin n_press++; press_t = cyc; end
        if (short_pulse)   begin n_short++; short_t = cyc; end
        if (long_pulse)    begin n_long++;  long_t  = cyc; end
        if (repeat_pulse)  begin n_rep++;   rep_t.push_back(cyc); end
        if (release_pulse) begin n_rel++;   rel_t   = cyc; end
        if (held) n_held++;
        if ((press_pulse && p_press) || (short_pulse && p_short) || (long_pulse && p_long) ||
            (repeat_pulse && p_rep) || (release_pulse && p_rel)) n_stretch++;
        p_press = press_pulse; p_short = short_pulse; p_long = long_pulse;
        p_rep = repeat_pulse; p_rel = release_pulse;
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst = 1'b1; pb_debounced = 1'b0;
        #2;
        outs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
        tests++; if (outs !== 6'b0) begin fails++; $display("FAIL reset_async outs=%b exp=000000", outs); end
        tick(); tick();
        outs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
        tests++; if (outs !== 6'b0) begin fails++; $display("FAIL reset_clocked outs=%b exp=000000", outs); end
        rst = 1'b0;
        tick(); tick();
        outs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
        tests++; if (outs !== 6'b0) begin fails++; $display("FAIL reset_idle outs=%b exp=000000", outs); end
    endtask

    task automatic test_short();
        clear();
        pb_debounced = 1'b1; repeat (3) tick();
        pb_debounced = 1'b0; repeat (5) tick();
        tests++; if (n_press !== 1 || press_t !== 1) begin fails++; $display("FAIL short_press n=%0d t=%0d exp n=1 t=1", n_press, press_t); end
        tests++; if (n_short !== 1 || short_t !== 4) begin fails++; $display("FAIL short_short n=%0d t=%0d exp n=1 t=4", n_short, short_t); end
        tests++; if (n_rel !== 1 || rel_t !== 4) begin fails++; $display("FAIL short_release n=%0d t=%0d exp n=1 t=4", n_rel, rel_t); end
        tests++; if (n_long !== 0) begin fails++; $display("FAIL short_long n=%0d exp 0", n_long); end
        tests++; if (n_held !== 3) begin fails++; $display("FAIL short_held cycles=%0d exp 3", n_held); end
    endtask

    task automatic test_long_repeat();
        clear();
        pb_debounced = 1'b1; repeat (30) tick();
        pb_debounced = 1'b0; repeat (3) tick();
        tests++; if (press_t !== 1 || n_press !== 1) begin fails++; $display("FAIL long_press t=%0d n=%0d exp t=1 n=1", press_t, n_press); end
        tests++; if (long_t !== 9 || n_long !== 1) begin fails++; $display("FAIL long_pulse t=%0d n=%0d exp t=9 n=1", long_t, n_long); end
        tests++; if (n_rep !== 5) begin fails++; $display("FAIL long_repeat_count n=%0d exp 5", n_rep); end
        for (int i = 0; i < rep_t.size(); i++) begin
            tests++; if (rep_t[i] !== 13 + 4 * i) begin fails++; $display("FAIL long_repeat_time[%0d] t=%0d exp %0d", i, rep_t[i], 13 + 4 * i); end
        end
        tests++; if (rel_t !== 31 || n_rel !== 1) begin fails++; $display("FAIL long_release t=%0d n=%0d exp t=31 n=1", rel_t, n_rel); end
        tests++; if (n_short !== 0) begin fails++; $display("FAIL long_no_short n=%0d exp 0", n_short); end
        tests++; if (n_held !== 30) begin fails++; $display("FAIL long_held cycles=%0d exp 30", n_held); end
    endtask

    task automatic test_release_at_threshold();
        clear();
        pb_debounced = 1'b1; repeat (8) tick();
        pb_debounced = 1'b0; repeat (3) tick();
        tests++; if (short_t !== 9 || rel_t !== 9) begin fails++; $display("FAIL thr_long short_t=%0d rel_t=%0d exp 9 9", short_t, rel_t); end
        tests++; if (n_long !== 0) begin fails++; $display("FAIL thr_long_no_long n=%0d exp 0", n_long); end
        clear();
        pb_debounced = 1'b1; repeat (12) tick();
        pb_debounced = 1'b0; repeat (3) tick();
        tests++; if (n_long !== 1 || n_rep !== 0) begin fails++; $display("FAIL thr_repeat long=%0d rep=%0d exp 1 0", n_long, n_rep); end
        tests++; if (rel_t !== 13 || n_short !== 0) begin fails++; $display("FAIL thr_repeat_release rel_t=%0d short=%0d exp 13 0", rel_t, n_short); end
    endtask

    task automatic test_held_through_reset();
        rst = 1'b1; pb_debounced = 1'b1;
        tick(); tick();
        rst = 1'b0;
        clear();
        repeat (20) tick();
        tests++; if (n_press + n_short + n_long + n_rep + n_rel !== 0 || n_held !== 0) begin
            fails++; $display("FAIL held_reset_quiet events=%0d held=%0d exp 0 0", n_press + n_short + n_long + n_rep + n_rel, n_held);
        end
        pb_debounced = 1'b0; tick(); tick();
        pb_debounced = 1'b1; tick();
        tests++; if (press_pulse !== 1'b1 || held !== 1'b1) begin fails++; $display("FAIL held_reset_repress press=%b held=%b exp 1 1", press_pulse, held); end
        tick();
        tests++; if (n_press !== 1) begin fails++; $display("FAIL held_reset_press_once n=%0d exp 1", n_press); end
        pb_debounced = 1'b0; tick(); tick();
    endtask

    task automatic test_reset_in_long();
        logic [5:0] outs;
        clear();
        pb_debounced = 1'b1; repeat (10) tick();
        tests++; if (held !== 1'b1 || n_long !== 1) begin fails++; $display("FAIL rstlong_pre held=%b long=%0d exp 1 1", held, n_long); end
        #2 rst = 1'b1;
        #1;
        outs = {press_pulse, short_pulse, long_pulse, repeat_pulse, release_pulse, held};
        tests++; if (outs !== 6'b0) begin fails++; $display("FAIL rstlong_async outs=%b exp=000000", outs); end
        tick();
        rst = 1'b0;
        clear();
        repeat (10) tick();
        tests++; if (n_rep !== 0 || n_press !== 0 || n_held !== 0) begin fails++; $display("FAIL rstlong_after rep=%0d press=%0d held=%0d exp 0 0 0", n_rep, n_press, n_held); end
        pb_debounced = 1'b0; tick(); tick();
    endtask

    task automatic test_back_to_back();
        clear();
        pb_debounced = 1'b1; tick();
        pb_debounced = 1'b0; tick();
        pb_debounced = 1'b1; tick();
        pb_debounced = 1'b0; tick();
        tick(); tick();
        tests++; if (n_press !== 2 || press_t !== 3) begin fails++; $display("FAIL toggle_press n=%0d last=%0d exp 2 3", n_press, press_t); end
        tests++; if (n_short !== 2 || n_rel !== 2 || short_t !== 4) begin fails++; $display("FAIL toggle_short short=%0d rel=%0d last=%0d exp 2 2 4", n_short, n_rel, short_t); end
        tests++; if (n_held !== 2) begin fails++; $display("FAIL toggle_held cycles=%0d exp 2", n_held); end
        tests++; if (n_stretch !== 0) begin fails++; $display("FAIL toggle_stretch n=%0d exp 0", n_stretch); end
    endtask

    initial begin
        clear();
        test_reset();
        test_short();
        test_long_repeat();
        test_release_at_threshold();
        test_held_through_reset();
        test_reset_in_long();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
